lcd_bus_arbiter: RTL and testbench

Shares the single HD44780-style LCD bus between two byte-stream requesters, e.g. the face/CGRAM renderer and a status-text writer. It accepts one `{rs, data}` transaction at a time through a valid/ready handshake. It drives `lcd_rs`, `lcd_rw`, `lcd_data` and a correctly timed `lcd_en` pulse, then holds off for the controller's execution time. A per-transaction lock lets a requester keep the bus for atomic sequences, such as a CGRAM address followed by 8 row bytes, so the LCD address counter is never corrupted by interleaving.

---
 rtl/lcd_bus_arbiter_if.sv | 26 ++
 rtl/lcd_bus_arbiter.sv | 103 ++++++++++
 tb/tb_lcd_bus_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_arbiter_if.sv
// Requester handshakes plus the LCD pin bundle shared between the two
// byte-stream requesters and the arbiter.
interface lcd_arb_if;
  logic       req0_valid, req0_rs, req0_lock, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_rs, req1_lock, req1_ready;
  logic [7:0] req1_data;
  logic       lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;
  logic [1:0] grant;
  logic       busy;

  modport master (
    output req0_valid, req0_rs, req0_data, req0_lock,
    output req1_valid, req1_rs, req1_data, req1_lock,
    input  req0_ready, req1_ready,
    input  lcd_rs, lcd_rw, lcd_en, lcd_data, grant, busy
  );

  modport slave (
    input  req0_valid, req0_rs, req0_data, req0_lock,
    input  req1_valid, req1_rs, req1_data, req1_lock,
    output req0_ready, req1_ready,
    output lcd_rs, lcd_rw, lcd_en, lcd_data, grant, busy
  );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Two-requester HD44780 bus arbiter with timed enable strobe and per-transaction lock.
// Build option: LCD_ARB_FIXED_PRIORITY_EN selects fixed req0 priority instead of round-robin.
module lcd_bus_arbiter #(
  parameter int SETUP_CYCLES = 4,
  parameter int PULSE_CYCLES = 25,
  parameter int EXEC_CYCLES  = 2500,
  parameter int CLEAR_CYCLES = 100000
) (
  input logic     clk,
  input logic     reset,
  lcd_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, WAIT} state_t;

  localparam int M1   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int M2   = (EXEC_CYCLES > CLEAR_CYCLES) ? EXEC_CYCLES : CLEAR_CYCLES;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXC + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic [7:0]    lcd_data_q, lcd_data_d;
  logic [1:0]    grant_q, grant_d;
  logic          lock_q, lock_d;

  logic elig0, elig1, win1, rdy0, rdy1, is_clear;

  // Under lock only the current owner (grant_q) stays eligible; otherwise
  // grant_q doubles as the round-robin pointer (00 after reset -> req0 first).
  always_comb begin
    elig0 = bus.req0_valid && (!lock_q || grant_q[0]);
    elig1 = bus.req1_valid && (!lock_q || grant_q[1]);
`ifdef LCD_ARB_FIXED_PRIORITY_EN
    win1  = elig1 && !elig0;
`else
    win1  = elig1 && (!elig0 || grant_q[0]);
`endif
    rdy0  = (state_q == IDLE) && elig0 && !win1 && !reset;
    rdy1  = (state_q == IDLE) && win1 && !reset;
  end

  assign is_clear = !lcd_rs_q &&
                    (lcd_data_q == 8'h01 || lcd_data_q == 8'h02 || lcd_data_q == 8'h03);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_data_d = lcd_data_q;
    grant_d    = grant_q;
    lock_d     = lock_q;
    unique case (state_q)
      IDLE: if (rdy0 || rdy1) begin
        lcd_rs_d   = win1 ? bus.req1_rs   : bus.req0_rs;
        lcd_data_d = win1 ? bus.req1_data : bus.req0_data;
        lock_d     = win1 ? bus.req1_lock : bus.req0_lock;
        grant_d    = win1 ? 2'b10 : 2'b01;
        cnt_d      = CW'(SETUP_CYCLES - 1);
        state_d    = SETUP;
      end
      SETUP: if (cnt_q == '0) begin
        cnt_d   = CW'(PULSE_CYCLES - 1);
        state_d = PULSE;
      end else cnt_d = cnt_q - 1'b1;
      PULSE: if (cnt_q == '0) begin
        cnt_d   = is_clear ? CW'(CLEAR_CYCLES - 1) : CW'(EXEC_CYCLES - 1);
        state_d = WAIT;
      end else cnt_d = cnt_q - 1'b1;
      WAIT: if (cnt_q == '0) state_d = IDLE;
            else cnt_d = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= 8'h00;
      grant_q    <= 2'b00;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_data_q <= lcd_data_d;
      grant_q    <= grant_d;
      lock_q     <= lock_d;
    end
  end

  // lcd_en comes straight off the state flop so an async reset drops it at once.
  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.lcd_rs     = lcd_rs_q;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_en     = (state_q == PULSE);
  assign bus.lcd_data   = lcd_data_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Randomized bench for lcd_bus_arbiter: a transaction-level timing model predicts
// every output each cycle from accept time, wait length and the arbitration rules.
module tb_lcd_bus_arbiter;
  localparam int S = 2, P = 3, E = 6, C = 15;
`ifdef LCD_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  lcd_arb_if bus();
  lcd_bus_arbiter #(.SETUP_CYCLES(S), .PULSE_CYCLES(P), .EXEC_CYCLES(E), .CLEAR_CYCLES(C))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int vecs = 0, errs = 0, cyc = 0;
  // model state: accept cycle, first idle cycle, owner/lock, visible pins
  int m_acc = -1000, m_free = 0, m_last = 1, m_owner = 0;
  bit m_lock = 0, m_rs = 0;
  logic [7:0] m_data = 8'h00;
  logic [1:0] m_grant = 2'b00;
  logic [9:0] q0[$], q1[$];   // {lock, rs, data}
  int served[$];
  bit hold_on = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = -1000; m_free = 0; m_last = 1; m_owner = 0; m_lock = 0;
    m_rs = 0; m_data = 8'h00; m_grant = 2'b00;
  endtask

  task automatic feed();
    if (!bus.req0_valid && q0.size() > 0 && (hold_on || $urandom_range(3) != 0)) begin
      bus.req0_valid = 1'b1;
      {bus.req0_lock, bus.req0_rs, bus.req0_data} = q0[0];
    end
    if (!bus.req1_valid && q1.size() > 0 && (hold_on || $urandom_range(3) != 0)) begin
      bus.req1_valid = 1'b1;
      {bus.req1_lock, bus.req1_rs, bus.req1_data} = q1[0];
    end
  endtask

  task automatic step();
    bit idle, en, el0, el1, r0, r1, lk, rs;
    logic [7:0] d;
    int win;
    @(negedge clk);
    idle = (cyc >= m_free);
    en   = (cyc >= m_acc + 1 + S) && (cyc <= m_acc + S + P);
    el0  = bus.req0_valid && (!m_lock || m_owner == 0);
    el1  = bus.req1_valid && (!m_lock || m_owner == 1);
    win  = -1;
    if (el0 && el1) win = FIXED ? 0 : ((m_last == 0) ? 1 : 0);
    else if (el0) win = 0;
    else if (el1) win = 1;
    r0 = idle && win == 0;
    r1 = idle && win == 1;
    chk("req0_ready", bus.req0_ready, r0);
    chk("req1_ready", bus.req1_ready, r1);
    chk("lcd_en", bus.lcd_en, en);
    chk("busy", bus.busy, !idle);
    chk("lcd_rs", bus.lcd_rs, m_rs);
    chk("lcd_data", bus.lcd_data, m_data);
    chk("grant", bus.grant, m_grant);
    chk("lcd_rw", bus.lcd_rw, 1'b0);
    @(posedge clk); #1;
    if (r0 || r1) begin
      if (win == 0) begin
        {lk, rs, d} = {bus.req0_lock, bus.req0_rs, bus.req0_data};
        void'(q0.pop_front()); bus.req0_valid = 1'b0;
      end else begin
        {lk, rs, d} = {bus.req1_lock, bus.req1_rs, bus.req1_data};
        void'(q1.pop_front()); bus.req1_valid = 1'b0;
      end
      m_acc = cyc;
      m_free = cyc + 1 + S + P + ((!rs && d >= 8'h01 && d <= 8'h03) ? C : E);
      m_last = win; m_owner = win; m_lock = lk; m_rs = rs; m_data = d;
      m_grant = (win == 0) ? 2'b01 : 2'b10;
      served.push_back(win);
    end
    cyc++;
    feed();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || cyc < m_free) && n < 3000) begin
      step(); n++;
    end
    chk({tag, "_drain_timeout"}, (n >= 3000), 1'b0);
  endtask

  function automatic logic [9:0] rnd_item();
    logic [7:0] d;
    d = ($urandom_range(3) == 0) ? 8'($urandom_range(3)) : 8'($urandom);
    return {($urandom_range(3) == 0), 1'($urandom), d};
  endfunction

  initial begin
    bus.req0_valid = 0; bus.req0_rs = 0; bus.req0_data = 0; bus.req0_lock = 0;
    bus.req1_valid = 0; bus.req1_rs = 0; bus.req1_data = 0; bus.req1_lock = 0;

    // reset state, ready held low while reset is high
    bus.req0_valid = 1; bus.req1_valid = 1;
    @(negedge clk);
    chk("rst_ready0", bus.req0_ready, 1'b0);
    chk("rst_ready1", bus.req1_ready, 1'b0);
    chk("rst_en", bus.lcd_en, 1'b0);
    chk("rst_data", bus.lcd_data, 8'h00);
    chk("rst_grant", bus.grant, 2'b00);
    chk("rst_busy", bus.busy, 1'b0);
    bus.req0_valid = 0; bus.req1_valid = 0;
    @(posedge clk); #1 reset = 1'b0;

    // single data write
    hold_on = 1;
    q0.push_back({1'b0, 1'b1, 8'h41});
    feed();
    drain("single");

    // clear display then a data byte from req1
    q1.push_back({1'b0, 1'b0, 8'h01});
    q1.push_back({1'b0, 1'b1, 8'h55});
    feed();
    drain("clear");

    // contention, no lock
    for (int i = 0; i < 4; i++) begin
      q0.push_back({1'b0, 1'b1, 8'(8'h10 + i)});
      q1.push_back({1'b0, 1'b1, 8'(8'h20 + i)});
    end
    feed();
    drain("contend");

    // locked CGRAM burst from req0 while req1 waits
    served.delete();
    q0.push_back({1'b1, 1'b0, 8'h40});
    for (int i = 0; i < 8; i++) q0.push_back({(i < 7), 1'b1, 8'(i)});
    feed();
    step();
    q1.push_back({1'b0, 1'b1, 8'hAA});
    feed();
    drain("lock");
    chk("lock_count", served.size(), 10);
    for (int i = 0; i < 9 && i < served.size(); i++) chk("lock_order_req0", served[i], 0);
    if (served.size() > 9) chk("lock_then_req1", served[9], 1);

    // reset during PULSE
    q1.push_back({1'b0, 1'b1, 8'h77});
    feed();
    begin
      int n = 0;
      while (!(cyc >= m_acc + 1 + S && cyc <= m_acc + S + P) && n < 200) begin step(); n++; end
      chk("pulse_reach_timeout", (n >= 200), 1'b0);
    end
    #2 reset = 1'b1;
    #1;
    chk("midrst_en", bus.lcd_en, 1'b0);
    chk("midrst_data", bus.lcd_data, 8'h00);
    chk("midrst_grant", bus.grant, 2'b00);
    chk("midrst_busy", bus.busy, 1'b0);
    model_reset();
    q0.push_back({1'b0, 1'b1, 8'h33});
    q1.push_back({1'b0, 1'b1, 8'h44});
    feed();
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    served.delete();
    drain("after_rst");
    if (served.size() > 0) chk("after_rst_first", served[0], 0);
    chk("after_rst_count", served.size(), 2);

    // randomized traffic with locks, clears and idle gaps
    hold_on = 0;
    for (int i = 0; i < 1500; i++) begin
      if (q0.size() == 0 && $urandom_range(1) == 1) q0.push_back(rnd_item());
      if (q1.size() == 0 && $urandom_range(2) == 0) q1.push_back(rnd_item());
      step();
    end
    q0.push_back({1'b0, 1'b1, 8'hE0});
    q1.push_back({1'b0, 1'b1, 8'hE1});
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
